icache_2way: RTL

//  Two-way set-associative, read-only instruction cache between IF and MEMctrl.

---
 rtl/icache_pkg.sv | 15 +
 rtl/icache_way_array.sv | 50 +++++
 rtl/icache_2way.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared constants for the two-way instruction cache: FSM encodings, word width
// and a small width helper.
package icache_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  function automatic int min1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/icache_way_array.sv
// One way of the instruction cache: per-set valid bit, tag and full data line.
// Read is combinational on rd_idx; clr_all wins over a same-cycle write.
module icache_way_array
  import icache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 6,
  parameter int TAG_W      = 22
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [IDX_W-1:0]                    rd_idx,
  output logic                                rd_valid,
  output logic [TAG_W-1:0]                    rd_tag,
  output logic [LINE_WORDS-1:0][WORD_W-1:0]   rd_line,
  input  logic                                we,
  input  logic [IDX_W-1:0]                    wr_idx,
  input  logic [TAG_W-1:0]                    wr_tag,
  input  logic [LINE_WORDS-1:0][WORD_W-1:0]   wr_line,
  input  logic                                clr_all
);

  logic [SETS-1:0]                     valid_q, valid_d;
  logic [TAG_W-1:0]                    tag_mem  [SETS];
  logic [LINE_WORDS-1:0][WORD_W-1:0]   data_mem [SETS];

  always_comb begin
    valid_d = valid_q;
    if (clr_all) valid_d = '0;
    else if (we) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];

endmodule

// File: rtl/icache_2way.sv
// Two-way set-associative read-only instruction cache with burst line refill,
// 1-bit LRU per set and flush. Define ICACHE_STATS_EN for hit/miss counters.
module icache_2way
  import icache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_valid,
  output logic [WORD_W-1:0] ins,
  output logic              ins_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic [WORD_W-1:0] mem_data,
  input  logic              mem_valid
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int BEAT_W  = min1(OFF_W);
  localparam int LADDR_W = ADDR_W - OFF_W - 2;
  localparam int TAG_W   = LADDR_W - IDX_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

  logic [LADDR_W-1:0] pc_line;
  logic [IDX_W-1:0]   pc_idx;
  logic [TAG_W-1:0]   pc_tag;
  logic [BEAT_W-1:0]  pc_off;
  logic               unused_pc_lsbs;

  assign pc_line        = pc[ADDR_W-1:OFF_W+2];
  assign pc_idx         = pc_line[IDX_W-1:0];
  assign pc_tag         = pc_line[LADDR_W-1:IDX_W];
  assign unused_pc_lsbs = ^pc[1:0];

  logic [1:0]         state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               mem_req_q, mem_req_d;
  logic [WORD_W-1:0]  ins_q, ins_d;
  logic               ins_valid_q, ins_valid_d;
  logic [SETS-1:0]    lru_q, lru_d;
  logic               victim_q, victim_d;
  logic [LADDR_W-1:0] req_line_q, req_line_d;
  logic [BEAT_W-1:0]  req_off_q, req_off_d;
  line_t              line_buf_q, line_buf_d;

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  assign req_idx = req_line_q[IDX_W-1:0];
  assign req_tag = req_line_q[LADDR_W-1:IDX_W];

  generate
    if (OFF_W == 0) begin : g_one_word
      assign pc_off   = '0;
      assign mem_addr = {req_line_q, 2'b00};
    end else begin : g_multi_word
      assign pc_off   = pc[OFF_W+1:2];
      assign mem_addr = {req_line_q, beat_q, 2'b00};
    end
  endgenerate

  logic [1:0]       way_valid;
  logic [TAG_W-1:0] way_tag  [2];
  line_t            way_line [2];
  logic             install_we;
  line_t            fill_line;

  for (genvar w = 0; w < 2; w++) begin : g_way
    icache_way_array #(
      .SETS(SETS), .LINE_WORDS(LINE_WORDS), .IDX_W(IDX_W), .TAG_W(TAG_W)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (pc_idx),
      .rd_valid (way_valid[w]),
      .rd_tag   (way_tag[w]),
      .rd_line  (way_line[w]),
      .we       (install_we && (victim_q == 1'(w))),
      .wr_idx   (req_idx),
      .wr_tag   (req_tag),
      .wr_line  (fill_line),
      .clr_all  (rdy && flush)
    );
  end

  // A flush in the lookup cycle forces a miss; the pulse cycle never re-looks-up the held pc.
  logic        hit0, hit1, hit, lookup;
  line_t       hit_line;
  logic [WORD_W-1:0] hit_word;

  assign hit0     = way_valid[0] && (way_tag[0] == pc_tag);
  assign hit1     = way_valid[1] && (way_tag[1] == pc_tag);
  assign hit      = (hit0 || hit1) && !flush;
  assign hit_line = hit1 ? way_line[1] : way_line[0];
  assign hit_word = hit_line[pc_off];
  assign lookup   = (state_q == ST_IDLE) && pc_valid && !ins_valid_q;

  always_comb begin
    fill_line         = line_buf_q;
    fill_line[beat_q] = mem_data;
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    mem_req_d   = mem_req_q;
    ins_d       = ins_q;
    ins_valid_d = ins_valid_q;
    lru_d       = lru_q;
    victim_d    = victim_q;
    req_line_d  = req_line_q;
    req_off_d   = req_off_q;
    line_buf_d  = line_buf_q;
    install_we  = 1'b0;
    if (rdy) begin
      ins_valid_d = 1'b0;
      if (flush) lru_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (lookup) begin
            if (hit) begin
              ins_valid_d   = 1'b1;
              ins_d         = hit_word;
              lru_d[pc_idx] = hit0;
            end else begin
              if (flush || !way_valid[0]) victim_d = 1'b0;
              else if (!way_valid[1])     victim_d = 1'b1;
              else                        victim_d = lru_q[pc_idx];
              req_line_d = pc_line;
              req_off_d  = pc_off;
              beat_d     = '0;
              mem_req_d  = 1'b1;
              state_d    = ST_REFILL;
            end
          end
        end
        ST_REFILL: begin
          if (flush) begin
            mem_req_d = 1'b0;
            beat_d    = '0;
            state_d   = ST_IDLE;
          end else if (mem_valid) begin
            line_buf_d = fill_line;
            if (beat_q == LAST_BEAT) begin
              install_we     = 1'b1;
              lru_d[req_idx] = !victim_q;
              mem_req_d      = 1'b0;
              beat_d         = '0;
              ins_d          = fill_line[req_off_q];
              ins_valid_d    = pc_valid;
              state_d        = ST_RESP;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
        ST_RESP: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      mem_req_q   <= 1'b0;
      ins_q       <= '0;
      ins_valid_q <= 1'b0;
      lru_q       <= '0;
      victim_q    <= 1'b0;
      req_line_q  <= '0;
      req_off_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      mem_req_q   <= mem_req_d;
      ins_q       <= ins_d;
      ins_valid_q <= ins_valid_d;
      lru_q       <= lru_d;
      victim_q    <= victim_d;
      req_line_q  <= req_line_d;
      req_off_q   <= req_off_d;
    end
  end

  always_ff @(posedge clk) line_buf_q <= line_buf_d;

  assign ins       = ins_q;
  assign ins_valid = ins_valid_q && rdy;
  assign mem_req   = mem_req_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (rdy && lookup) begin
      if (hit && hit_cnt_q != '1)         hit_cnt_d  = hit_cnt_q + 32'd1;
      else if (!hit && miss_cnt_q != '1)  miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
